// File: rtl/mdc_pkg.sv
// Shared mode encodings and width helpers for the MDC parametrised determinant engine.
package mdc_pkg;

  typedef enum logic [4:0] {
    MODE_2X2 = 5'b00100,
    MODE_3X3 = 5'b00110,
    MODE_4X4 = 5'b10110
  } mode_e;

  function automatic int cw_of(input int p);
    return (1 << p) - 1;
  endfunction

  function automatic int w2(input int p);
    return 2 * (cw_of(p) - p) + 1;
  endfunction

  function automatic int w3(input int p);
    return 3 * (cw_of(p) - p) + 3;
  endfunction

  function automatic int w4(input int p);
    return 4 * (cw_of(p) - p) + 5;
  endfunction

  function automatic int out_w(input int p);
    return 9 * w2(p);
  endfunction

endpackage

// File: rtl/hamming_sec_dec.sv
// Combinational Hamming single-error corrector; code[CW-i] carries position i (1-based).
module hamming_sec_dec #(
  parameter int CW = 15,
  parameter int DW = 11
) (
  input  logic [CW-1:0] code,
  output logic [DW-1:0] data,
  output logic          corr
);

  localparam int SW = $clog2(CW + 1);

  // Position of the n-th data bit: data fills non-power-of-two positions in ascending order.
  function automatic int dpos(input int n);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i <= CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == n) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic [SW-1:0] syn;

  always_comb begin
    syn = '0;
    for (int i = 1; i <= CW; i++) begin
      if (code[CW-i]) syn = syn ^ SW'(i);
    end
  end

  // A syndrome past the shortened width matches no data position, so nothing flips.
  assign corr = |syn;

  for (genvar j = 0; j < DW; j++) begin : g_data
    localparam int POS = dpos(j);
    assign data[DW-1-j] = code[CW-POS] ^ (syn == SW'(POS));
  end

endmodule

// File: rtl/mdc_param_engine.sv
// Streaming 4x4 minor/determinant engine: Hamming-corrected beats, row-wise minor accumulation,
// two-stage result pipeline after the last beat.
module mdc_param_engine
  import mdc_pkg::*;
#(
  parameter int  P       = 4,
  parameter int  MODE_CW = 9,
  localparam int CW      = cw_of(P),
  localparam int OUT_W   = out_w(P)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [CW-1:0]      in_data,
  input  logic [MODE_CW-1:0] in_mode,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic [4:0]         out_corr,
  output logic               out_err
);

  localparam int DW  = CW - P;
  localparam int W2  = w2(P);
  localparam int W3  = w3(P);
  localparam int W4  = w4(P);
  localparam int MDW = 5;

  typedef logic signed [DW-1:0] elem_t;
  typedef logic signed [W2-1:0] m2_t;
  typedef logic signed [W3-1:0] m3_t;
  typedef logic signed [W4-1:0] m4_t;

  // Column pairs (PA<PB) in minor-table order, and the three columns left when column x is dropped.
  localparam int PA  [6] = '{0, 0, 0, 1, 1, 2};
  localparam int PB  [6] = '{1, 2, 3, 2, 3, 3};
  localparam int CP  [3] = '{0, 3, 5};
  localparam int TC0 [4] = '{1, 0, 0, 0};
  localparam int TC1 [4] = '{2, 2, 1, 1};
  localparam int TC2 [4] = '{3, 3, 3, 2};

  function automatic int pidx(input int a, input int b);
    if (a == 0) return b - 1;
    if (a == 1) return b + 1;
    return 5;
  endfunction

  logic [DW-1:0]  beat_data;
  logic           beat_corr;
  logic [MDW-1:0] mode_dec;
  logic           mode_corr;

  hamming_sec_dec #(.CW(CW), .DW(DW)) u_data_dec (
    .code (in_data),
    .data (beat_data),
    .corr (beat_corr)
  );

  hamming_sec_dec #(.CW(MODE_CW), .DW(MDW)) u_mode_dec (
    .code (in_mode),
    .data (mode_dec),
    .corr (mode_corr)
  );

  // Handshake: a beat is consumed on every rising edge with in_valid=1; there is no backpressure,
  // in_valid=0 cycles are gaps and leave the beat counter untouched.
  logic [3:0]     beat;
  elem_t          rows [4][4];
  logic           rd_q;
  logic [1:0]     rd_row;
  logic [MDW-1:0] mode_q;
  logic [4:0]     corr_acc;
  logic [5:0]     corr_sum;
  logic [4:0]     corr_next;

  always_comb begin
    if (beat == 4'd0) corr_sum = 6'(beat_corr) + 6'(mode_corr);
    else              corr_sum = 6'(corr_acc) + 6'(beat_corr);
    corr_next = (corr_sum > 6'd31) ? 5'd31 : corr_sum[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat     <= '0;
      rd_q     <= 1'b0;
      rd_row   <= '0;
      mode_q   <= '0;
      corr_acc <= '0;
    end else begin
      rd_q <= 1'b0;
      if (in_valid) begin
        rows[beat[3:2]][beat[1:0]] <= elem_t'(beat_data);
        beat     <= beat + 4'd1;
        corr_acc <= corr_next;
        if (beat == 4'd0) mode_q <= mode_dec;
        if (beat[1:0] == 2'd3) begin
          rd_q   <= 1'b1;
          rd_row <= beat[3:2];
        end
      end
    end
  end

  // One cycle after a row completes: 2x2 minors of (previous,current) rows, 3x3 minors by
  // expanding the current row over the stored 2x2 minors, and the 4x4 along row 3.
  elem_t up [4];
  elem_t lo [4];
  m2_t   m2_src [6];
  m2_t   m2_new [6];
  m3_t   m3_new [4];
  m4_t   det_new;

  m2_t   m2_01 [6];
  m2_t   m2_12 [6];
  m2_t   m2_23 [3];
  m3_t   m3_012 [4];
  m3_t   m3_123 [2];
  m4_t   det_q;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      up[j] = rows[rd_row][j];
      lo[j] = rows[rd_row - 2'd1][j];
    end
    for (int p = 0; p < 6; p++) begin
      m2_src[p] = (rd_row == 2'd2) ? m2_01[p] : m2_12[p];
      m2_new[p] = m2_t'(lo[PA[p]]) * m2_t'(up[PB[p]]) - m2_t'(lo[PB[p]]) * m2_t'(up[PA[p]]);
    end
    for (int x = 0; x < 4; x++) begin
      m3_new[x] = m3_t'(up[TC0[x]]) * m3_t'(m2_src[pidx(TC1[x], TC2[x])])
                - m3_t'(up[TC1[x]]) * m3_t'(m2_src[pidx(TC0[x], TC2[x])])
                + m3_t'(up[TC2[x]]) * m3_t'(m2_src[pidx(TC0[x], TC1[x])]);
    end
    det_new = m4_t'(up[1]) * m4_t'(m3_012[1]) + m4_t'(up[3]) * m4_t'(m3_012[3])
            - m4_t'(up[0]) * m4_t'(m3_012[0]) - m4_t'(up[2]) * m4_t'(m3_012[2]);
  end

  logic           fin_q;
  logic [MDW-1:0] fin_mode;
  logic [4:0]     fin_corr;

  always_ff @(posedge clk) begin
    if (rst) begin
      fin_q    <= 1'b0;
      fin_mode <= '0;
      fin_corr <= '0;
    end else begin
      fin_q <= rd_q && (rd_row == 2'd3);
      if (rd_q) begin
        case (rd_row)
          2'd1: m2_01 <= m2_new;
          2'd2: begin
            m2_12  <= m2_new;
            m3_012 <= m3_new;
          end
          2'd3: begin
            m2_23[0]  <= m2_new[CP[0]];
            m2_23[1]  <= m2_new[CP[1]];
            m2_23[2]  <= m2_new[CP[2]];
            m3_123[0] <= m3_new[3];
            m3_123[1] <= m3_new[0];
            det_q     <= det_new;
            fin_mode  <= mode_q;
            fin_corr  <= corr_acc;
          end
          default: ;
        endcase
      end
    end
  end

  logic [OUT_W-1:0] out_next;
  logic             err_next;

  always_comb begin
    out_next = '0;
    err_next = 1'b0;
    case (fin_mode)
      MODE_2X2: begin
        for (int c = 0; c < 3; c++) begin
          out_next[(8-c)*W2 +: W2] = m2_01[CP[c]];
          out_next[(5-c)*W2 +: W2] = m2_12[CP[c]];
          out_next[(2-c)*W2 +: W2] = m2_23[c];
        end
      end
      MODE_3X3: begin
        out_next[3*W3 +: W3] = m3_012[3];
        out_next[2*W3 +: W3] = m3_012[0];
        out_next[1*W3 +: W3] = m3_123[0];
        out_next[0*W3 +: W3] = m3_123[1];
      end
      MODE_4X4: out_next[W4-1:0] = det_q;
      default:  err_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_corr  <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= fin_q;
      if (fin_q) begin
        out_data <= out_next;
        out_corr <= fin_corr;
        out_err  <= err_next;
      end
    end
  end

endmodule
